// File: rtl/cache_pkg.sv
// Shared constants, address slicing helpers and line metadata for the 2-way write-back cache.
package cache_pkg;

    localparam int WAYS     = 2;
    localparam int SETS     = 64;
    localparam int WORDS    = 4;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 22;
    localparam int IDX_W    = 6;
    localparam int WORD_W   = 2;

    localparam int TAG_LSB  = 10;
    localparam int IDX_LSB  = 4;
    localparam int WORD_LSB = 2;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[TAG_LSB +: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return a[IDX_LSB +: IDX_W];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
        return a[WORD_LSB +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: tag/valid/dirty/data storage for all sets, tag compare and word read-out.
module cache_way
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] word,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic              fill,
    input  logic              edit,
    input  logic              inv,
    input  logic [DATA_W-1:0] din,
    output logic              match,
    output line_meta_t        meta,
    output logic [DATA_W-1:0] rdata
);

    line_meta_t        meta_mem [SETS];
    logic [DATA_W-1:0] data_mem [SETS][WORDS];

    // The controller asserts at most one of fill/edit/inv for this way in a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                meta_mem[s] <= '0;
                for (int w = 0; w < WORDS; w++) begin
                    data_mem[s][w] <= '0;
                end
            end
        end else if (inv) begin
            meta_mem[idx].valid <= 1'b0;
            meta_mem[idx].dirty <= 1'b0;
        end else if (fill) begin
            meta_mem[idx]        <= '{valid: 1'b1, dirty: 1'b0, tag: lookup_tag};
            data_mem[idx][word]  <= din;
        end else if (edit) begin
            meta_mem[idx].dirty  <= 1'b1;
            data_mem[idx][word]  <= din;
        end
    end

    assign meta  = meta_mem[idx];
    assign rdata = data_mem[idx][word];
    assign match = meta.valid && (meta.tag == lookup_tag);

endmodule

// File: rtl/cache_core.sv
// 2-way set-associative cache storage core: way select, replacement and command decode.
// CACHE_LRU_EN selects LRU replacement; otherwise each set uses a round-robin pointer.
module cache_core
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              store,
    input  logic              edit,
    input  logic              invalid,
    input  logic [DATA_W-1:0] din,
    output logic              hit,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag
);

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [TAG_W-1:0]  lookup_tag;
    logic [1:0]        unused_byte_offset;

    logic              match_w [WAYS];
    line_meta_t        meta_w  [WAYS];
    logic [DATA_W-1:0] rdata_w [WAYS];

    logic [WAYS-1:0]   fill_we;
    logic [WAYS-1:0]   edit_we;
    logic [WAYS-1:0]   inv_we;
    logic              sel;
    logic              victim;
    logic              do_inv;
    logic              do_store;
    logic              do_edit;
    logic [SETS-1:0]   repl;

    assign idx                = addr_idx(addr);
    assign word               = addr_word(addr);
    assign lookup_tag         = addr_tag(addr);
    assign unused_byte_offset = addr[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way u_way (
            .clk        (clk),
            .rst        (rst),
            .idx        (idx),
            .word       (word),
            .lookup_tag (lookup_tag),
            .fill       (fill_we[w]),
            .edit       (edit_we[w]),
            .inv        (inv_we[w]),
            .din        (din),
            .match      (match_w[w]),
            .meta       (meta_w[w]),
            .rdata      (rdata_w[w])
        );
    end

    assign hit = match_w[0] || match_w[1];

    // Invalid ways are filled before anything is evicted; way 0 wins a double match.
    always_comb begin
        victim = repl[idx];
        if (!meta_w[0].valid) begin
            victim = 1'b0;
        end else if (!meta_w[1].valid) begin
            victim = 1'b1;
        end

        sel = victim;
        if (hit) begin
            sel = match_w[0] ? 1'b0 : 1'b1;
        end

        do_inv   = invalid && hit;
        do_store = !invalid && store;
        do_edit  = !invalid && !store && edit && hit;

        for (int w = 0; w < WAYS; w++) begin
            fill_we[w] = do_store && (sel == 1'(w));
            edit_we[w] = do_edit  && (sel == 1'(w));
            inv_we[w]  = do_inv   && (sel == 1'(w));
        end
    end

    // repl[s] names the way to evict from set s once both ways are valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repl <= '0;
`ifdef CACHE_LRU_EN
        end else if (do_store || do_edit) begin
            repl[idx] <= ~sel;
`else
        end else if (do_store && !hit && meta_w[0].valid && meta_w[1].valid) begin
            repl[idx] <= ~repl[idx];
`endif
        end
    end

    assign dout  = rdata_w[sel];
    assign valid = meta_w[sel].valid;
    assign dirty = meta_w[sel].dirty;
    assign tag   = meta_w[sel].tag;

endmodule

// File: tb/tb_cache_core.sv
// Directed bench for cache_core: a per-set behavioural model checked every cycle plus literal spot checks.
module tb_cache_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        store;
    logic        edit;
    logic        invalid;
    logic [31:0] din;
    logic        hit;
    logic [31:0] dout;
    logic        valid;
    logic        dirty;
    logic [21:0] tag;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    bit          m_valid [64][2];
    bit          m_dirty [64][2];
    logic [21:0] m_tag   [64][2];
    logic [31:0] m_data  [64][2][4];
    int          m_repl  [64];

    typedef struct {
        logic        hit;
        logic [31:0] dout;
        logic        valid;
        logic        dirty;
        logic [21:0] tag;
    } exp_t;

    cache_core dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .store   (store),
        .edit    (edit),
        .invalid (invalid),
        .din     (din),
        .hit     (hit),
        .dout    (dout),
        .valid   (valid),
        .dirty   (dirty),
        .tag     (tag)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) begin
            m_repl[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                for (int k = 0; k < 4; k++) m_data[s][w][k] = '0;
            end
        end
    endfunction

    // Way the outputs describe: the hit way, else first empty way, else the replacement choice.
    function automatic int model_sel(input logic [31:0] a, output bit h);
        int          s   = int'((a >> 4) & 32'h3F);
        logic [21:0] tg  = a[31:10];
        int          sel = 0;
        h = 1'b0;
        for (int w = 1; w >= 0; w--) begin
            if (m_valid[s][w] && m_tag[s][w] == tg) begin
                h   = 1'b1;
                sel = w;
            end
        end
        if (!h) begin
            if (!m_valid[s][0])      sel = 0;
            else if (!m_valid[s][1]) sel = 1;
            else                     sel = m_repl[s];
        end
        return sel;
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] a);
        exp_t e;
        bit   h;
        int   s   = int'((a >> 4) & 32'h3F);
        int   k   = int'((a >> 2) & 32'h3);
        int   sel = model_sel(a, h);
        e.hit   = h;
        e.dout  = m_data[s][sel][k];
        e.valid = m_valid[s][sel];
        e.dirty = m_dirty[s][sel];
        e.tag   = m_tag[s][sel];
        return e;
    endfunction

    function automatic void model_commit(input logic [31:0] a, input bit st, input bit ed,
                                         input bit iv, input logic [31:0] d);
        bit h;
        int s   = int'((a >> 4) & 32'h3F);
        int k   = int'((a >> 2) & 32'h3);
        int sel = model_sel(a, h);
        if (iv) begin
            if (h) begin
                m_valid[s][sel] = 1'b0;
                m_dirty[s][sel] = 1'b0;
            end
        end else if (st) begin
`ifndef CACHE_LRU_EN
            if (!h && m_valid[s][0] && m_valid[s][1]) m_repl[s] = 1 - m_repl[s];
`else
            m_repl[s] = 1 - sel;
`endif
            m_valid[s][sel]   = 1'b1;
            m_dirty[s][sel]   = 1'b0;
            m_tag[s][sel]     = a[31:10];
            m_data[s][sel][k] = d;
        end else if (ed && h) begin
            m_dirty[s][sel]   = 1'b1;
            m_data[s][sel][k] = d;
`ifdef CACHE_LRU_EN
            m_repl[s] = 1 - sel;
`endif
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (check_en) begin
            e = model_lookup(addr);
            vectors++;
            if (hit !== e.hit || dout !== e.dout || valid !== e.valid ||
                dirty !== e.dirty || tag !== e.tag) begin
                miscompares++;
                $display("[TB] FAIL cycle addr=%h got hit=%b dout=%h valid=%b dirty=%b tag=%h expected hit=%b dout=%h valid=%b dirty=%b tag=%h",
                         addr, hit, dout, valid, dirty, tag, e.hit, e.dout, e.valid, e.dirty, e.tag);
            end
        end
    end

    // Drive one command for one clock edge; returns 1 ns after that edge with commands idle.
    task automatic applyStimulus(input logic [31:0] a, input bit st, input bit ed,
                                 input bit iv, input logic [31:0] d);
        addr    = a;
        store   = st;
        edit    = ed;
        invalid = iv;
        din     = d;
        @(posedge clk);
        model_commit(a, st, ed, iv, d);
        #1;
        store   = 1'b0;
        edit    = 1'b0;
        invalid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a);
        applyStimulus(a, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput(input string name, input logic h, input logic [31:0] d,
                               input logic v, input logic dy, input logic [21:0] t);
        #1;
        vectors++;
        if (hit !== h || dout !== d || valid !== v || dirty !== dy || tag !== t) begin
            miscompares++;
            $display("[TB] FAIL %s addr=%h got hit=%b dout=%h valid=%b dirty=%b tag=%h expected hit=%b dout=%h valid=%b dirty=%b tag=%h",
                     name, addr, hit, dout, valid, dirty, tag, h, d, v, dy, t);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          cmd;
        rst     = 1'b0;
        addr    = '0;
        store   = 1'b0;
        edit    = 1'b0;
        invalid = 1'b0;
        din     = '0;
        model_reset();
        check_en = 1'b1;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 22'h0);

        applyStimulus(32'h00, 1'b1, 1'b0, 1'b0, 32'h11111111);
        applyStimulus(32'h04, 1'b1, 1'b0, 1'b0, 32'h11111111);
        applyStimulus(32'hA8, 1'b1, 1'b0, 1'b0, 32'h11111111);
        applyStimulus(32'h1C, 1'b1, 1'b0, 1'b0, 32'h11111111);
        lookup(32'h04);
        checkOutput("read_04", 1'b1, 32'h11111111, 1'b1, 1'b0, 22'h0);
        lookup(32'hA8);
        checkOutput("read_a8", 1'b1, 32'h11111111, 1'b1, 1'b0, 22'h0);
        lookup(32'h1C);
        checkOutput("read_1c", 1'b1, 32'h11111111, 1'b1, 1'b0, 22'h0);

        lookup(32'hB4);
        checkOutput("empty_b4", 1'b0, 32'h0, 1'b0, 1'b0, 22'h0);
        applyStimulus(32'hB4, 1'b0, 1'b1, 1'b0, 32'h33333333);
        checkOutput("edit_miss", 1'b0, 32'h0, 1'b0, 1'b0, 22'h0);

        applyStimulus(32'h08, 1'b0, 1'b1, 1'b0, 32'h22222222);
        checkOutput("edit_hit", 1'b1, 32'h22222222, 1'b1, 1'b1, 22'h0);
        lookup(32'h00);
        checkOutput("word0_kept", 1'b1, 32'h11111111, 1'b1, 1'b1, 22'h0);

        applyStimulus(32'h400, 1'b1, 1'b0, 1'b0, 32'h44444444);
        checkOutput("store_400", 1'b1, 32'h44444444, 1'b1, 1'b0, 22'h1);
        lookup(32'h800);
        checkOutput("victim_800", 1'b0, 32'h11111111, 1'b1, 1'b1, 22'h0);
        applyStimulus(32'h800, 1'b1, 1'b0, 1'b0, 32'h55555555);
        checkOutput("store_800", 1'b1, 32'h55555555, 1'b1, 1'b0, 22'h2);
        lookup(32'h00);
        checkOutput("evicted_00", 1'b0, 32'h44444444, 1'b1, 1'b0, 22'h1);
        lookup(32'h400);
        checkOutput("hit_400", 1'b1, 32'h44444444, 1'b1, 1'b0, 22'h1);
        lookup(32'h800);
        checkOutput("hit_800", 1'b1, 32'h55555555, 1'b1, 1'b0, 22'h2);

        applyStimulus(32'h400, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("inv_400", 1'b0, 32'h44444444, 1'b0, 1'b0, 22'h1);
        applyStimulus(32'h800, 1'b1, 1'b1, 1'b1, 32'h66666666);
        checkOutput("inv_priority", 1'b0, 32'h55555555, 1'b0, 1'b0, 22'h2);
        applyStimulus(32'h10, 1'b1, 1'b1, 1'b0, 32'h77777777);
        checkOutput("store_priority", 1'b1, 32'h77777777, 1'b1, 1'b0, 22'h0);

        // Mixed traffic over 3 sets and 5 tags so both replacement schemes see full sets.
        for (int i = 0; i < 60; i++) begin
            a   = ((32'(i * 7) % 5) << 10) | ((32'(i) % 3) << 4) | ((32'(i) % 4) << 2);
            cmd = (i * 3) % 7;
            applyStimulus(a, cmd < 3, cmd == 3 || cmd == 4, cmd == 5, 32'hA0000000 + 32'(i));
        end

        addr    = 32'h1C;
        store   = 1'b1;
        din     = 32'h99999999;
        #2 rst  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        store   = 1'b0;
        checkOutput("reset_mid_store", 1'b0, 32'h0, 1'b0, 1'b0, 22'h0);
        lookup(32'hA8);
        checkOutput("reset_cleared", 1'b0, 32'h0, 1'b0, 1'b0, 22'h0);

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_core.md
Name: cache_core

Overview:
- Storage core of a 2-way set-associative, write-back data cache: tag, valid, dirty, LRU and data arrays, with combinational lookup.
- An external cache controller drives `store` (line fill from memory), `edit` (CPU write on hit) and `invalid` (line invalidation).
- The controller uses `hit`, `dout`, `valid`, `dirty` and `tag` to decide on a hit, or a victim writeback.
- Address split: tag[31:10] (22 b), index[9:4] (64 sets), word[3:2] (4 words per 16-byte line), addr[1:0] ignored.

Parameters:
- WAYS, 2, associativity (fixed; only 2 supported).
- SETS, 64, number of sets (index width 6).
- WORDS, 4, 32-bit words per line.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address.
- store  in  1  fill word `din` into the line for `addr`.
- edit  in  1  CPU write of `din` on hit.
- invalid  in  1  invalidate the line matching `addr`.
- din  in  32  write data.
- hit  out  1  a valid way's tag matches addr[31:10].
- dout  out  32  selected word of the selected way.
- valid  out  1  valid bit of the selected way.
- dirty  out  1  dirty bit of the selected way.
- tag  out  22  stored tag of the selected way.

Behaviour:
- Reset (rst=0, async): all valid, dirty, tag and LRU bits are cleared; data words are cleared to 0. With no command active, every lookup then gives hit=0, dout=0, valid=0, dirty=0, tag=0.
- Lookup is purely combinational from `addr` (zero latency).
  - Selected way = matching valid way on a hit; otherwise the replacement victim.
  - All outputs reflect the selected way and word addr[3:2].
  - On a miss the outputs describe the victim, so the controller can write it back when valid=1 and dirty=1.
  - If both ways match (illegal state), way 0 wins.
- Victim selection: an invalid way is chosen first (way 0 before way 1); otherwise the LRU way.
- Commands are sampled at posedge clk. Priority: invalid > store > edit; only one takes effect per cycle.
  - invalid: if hit, the matching way gets valid=0 and dirty=0; data and tag are unchanged. On a miss, no change.
  - store: the selected way (hit way, or victim on a miss) gets tag=addr[31:10], valid=1, dirty=0, and word[addr[3:2]]=din. Other words are untouched; the controller fills the whole line over 4 store cycles.
  - edit: if hit, word[addr[3:2]] of the hit way = din and dirty=1. On a miss, no state change.
- LRU update: on every effective store, and on every edit with a hit, the set's LRU bit marks the other way as least recently used. Lookups alone do not update LRU.
- The new state is visible on the outputs immediately after the clock edge.
- Reset asserted mid-command aborts the write; all state is cleared.

Optional Feature:
- CACHE_LRU_EN defined: LRU replacement as above.
- CACHE_LRU_EN undefined: each set has a round-robin pointer instead.
  - The pointer selects the victim when both ways are valid.
  - It toggles only on a store that misses with both ways valid.
  - Hits do not affect it; it resets to 0.

Decomposition:
- Shared package `cache_pkg` holds:
  - TAG_W=22, IDX_W=6, WORD_W=2;
  - address-field slicing constants;
  - the line-metadata typedef (valid, dirty, tag).
- Natural sub-module: `cache_way`. One instance per way; it holds the tag/valid/dirty/data arrays, does the compare and outputs its match and read data. The top level does way selection, replacement and command decode.

Test Plan:
- After reset, addr=0x0, no command -> hit=0, valid=0, dirty=0, tag=0, dout=0.
- Store din=0x11111111 at 0x00, 0x04, 0xA8, 0x1C, one per cycle, then read 0x04 -> hit=1, dout=0x11111111, valid=1, dirty=0, tag=0; 0xA8 (set 10) and 0x1C (set 1) also hit.
- Read 0xB4 (set 11, empty) -> hit=0, valid=0. Edit din=0x33333333 at 0xB4 -> no change; still hit=0, dout=0.
- Edit din=0x22222222 at 0x08 (set 0, hit) -> dout=0x22222222, dirty=1, hit=1; word 0x00 still reads 0x11111111.
- Conflict in set 0:
  - Stores at 0x400 and then 0x800 (tags 1 and 2), with no intervening edit to 0x00.
  - Before the 0x800 store, the outputs show victim tag=0, valid=1, dirty=1.
  - After it, 0x00 misses and 0x400 and 0x800 both hit.
- Invalid at 0x400 -> hit=0; assert rst=0 mid-store -> all lines invalid, the write is discarded.
